call_panel: RTL
===============

# call_panel

Hall/car call front end for the 3-floor `elevator` controller. It synchronises and debounces raw call buttons and latches each call. Latched calls drive the controller's `req` bus. A call is cleared once the controller reports door open at that floor. It sits directly upstream of `elevator`, sharing its `clk`, `rst` and `cur_floor`.

## Interface
- `DEBOUNCE`, 3: consecutive sampled cycles a synchronised button level must differ from its stable level before the stable level flips; legal 1..15
- `clk` input 1: system clock, all state on rising edge
- `rst` input 1: synchronous, active-high reset
- `btn` input 3: raw asynchronous call buttons, bit i = floor i, 1 = pressed
- `cur_floor` input 2: current floor from the floor sensor, same signal fed to `elevator`; value 3 is invalid
- `door_open` input 1: from `elevator`, 1 while the door is open at `cur_floor`
- `req` output 3: latched pending calls, connects to `elevator.req`
- `any_req` output 1: OR of `req`, registered

## Operation
- Per button: 2-flop synchroniser (`s1`→`s2`), then debounce counter `cnt` (4 bits) and stable level `stb`.
- Each edge:
  - if `s2 == stb`, then `cnt <= 0`;
  - else if `cnt == DEBOUNCE-1`, then `stb <= s2` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
- Press event `press[i]`: one-cycle pulse when `stb[i]` rises 0→1. Release and held level have no effect.
- Clear condition `clr[i]`: `door_open == 1` and `cur_floor == i`. `cur_floor == 3` clears nothing.
- Latch update per bit, priority high to low:
  - `clr[i]` → `req[i] <= 0`;
  - `press[i]` → `req[i] <= 1` (see Configuration for an already-set bit);
  - else hold.
- Press and clear in the same cycle for the same floor: clear wins. The call is already being served and is not re-latched.
- A press at a floor other than `cur_floor` while the door is open latches normally.
- Pulses or bounce shorter than `DEBOUNCE` consecutive synchronised cycles never change `stb`, so no call is raised.
- Multiple buttons are independent. Simultaneous presses latch all of them in the same cycle.
- `any_req` is registered from the next-state value of `req`, so it is coincident with `req`.

## Timing
- Reset values: `req = 3'b000`, `any_req = 0`. Internally `s1`, `s2`, `stb` and `cnt` are all 0.
- Latency: `btn[i]` first sampled high at edge 0 and held → `stb[i] = 1` after edge `DEBOUNCE+1` → `req[i] = 1` after edge `DEBOUNCE+2`. With default `DEBOUNCE=3`, that is edge 5.
- Clear latency: `req[i]` falls after the first edge at which `door_open == 1` and `cur_floor == i` are sampled.
- Reset mid-operation: on the reset edge all latched calls and debounce state are discarded. A button still held after reset is seen as a new press with full latency.
- No handshake with `elevator`: `req` is level, held until cleared.

## Configuration
- `CALL_CANCEL_EN` defined: a press event on a floor whose `req` bit is already 1 (and not being cleared) toggles it to 0. The button acts as cancel.
- Not defined: a press on an already-latched floor is ignored and `req` stays 1.
- Clear-wins priority is identical in both builds.

## Structure
- Package `elevator_pkg`:
  - `NUM_FLOORS = 3`, `FLOOR_W = 2`;
  - `typedef logic [FLOOR_W-1:0] floor_t`;
  - `typedef logic [NUM_FLOORS-1:0] floor_mask_t`.
- `elevator_pkg` is shared with `elevator`.
- Sub-module `button_debounce` holds the synchroniser, counter and stable flop, and outputs `press`. It is instantiated `NUM_FLOORS` times via generate.
- Latch, clear and cancel logic stay in `call_panel`.

## Test plan
- Reset, then hold `btn=3'b100` from edge 0 with `door_open=0` → `req=3'b100` and `any_req=1` after edge 5, not earlier.
- Glitch `btn[1]` high for 2 cycles, then low → `req` stays `3'b000` for ≥10 cycles.
- `req=3'b100`, `cur_floor=2`, assert `door_open` → `req=3'b000` one edge later. A press of `btn[2]` completing debounce while `door_open=1` and `cur_floor=2` leaves `req[2]=0`.
- `btn=3'b011` pressed together at `cur_floor=2`, `door_open=0` → `req=3'b011` on the same edge. Then `cur_floor=1` with `door_open=1` → `req=3'b001`.
- `req=3'b100`, second full press of `btn[2]` → `req` stays `3'b100` without `CALL_CANCEL_EN`; `req=3'b000` with it.
- `req=3'b101`, assert `rst` for 1 cycle while `btn[0]` held → `req=3'b000`. `req[0]` re-rises `DEBOUNCE+2` edges after the first sample following reset release.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: floor count and floor/mask types shared by call_panel and elevator
package elevator_pkg;
  localparam int NUM_FLOORS = 3;
  localparam int FLOOR_W = 2;
  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [NUM_FLOORS-1:0] floor_mask_t;
endpackage

// File: rtl/call_panel_if.sv
// call_panel_if: button, floor and door inputs plus latched call outputs of call_panel
interface call_panel_if;
  import elevator_pkg::*;
  floor_mask_t btn;
  floor_t cur_floor;
  logic door_open;
  floor_mask_t req;
  logic any_req;
  modport master(output btn, cur_floor, door_open, input req, any_req);
  modport slave(input btn, cur_floor, door_open, output req, any_req);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, debounce counter and rising-edge press pulse
module button_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic s1, s2, stb, stb_d;
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stb <= 1'b0;
      stb_d <= 1'b0;
      cnt <= 4'd0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      stb_d <= stb;
      if (s2 == stb) cnt <= 4'd0;
      else if (cnt == 4'(DEBOUNCE - 1)) begin
        stb <= s2;
        cnt <= 4'd0;
      end else cnt <= cnt + 4'd1;
    end
  end
  assign press = stb & ~stb_d;
endmodule

// File: rtl/call_panel.sv
// call_panel: debounced call latch for the elevator; CALL_CANCEL_EN makes a re-press cancel a call
module call_panel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input logic clk,
  input logic rst,
  call_panel_if.slave bus
);
`ifdef CALL_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif
  floor_mask_t press, clr, req, req_nx;
  logic any_req;
  genvar i;
  for (i = 0; i < NUM_FLOORS; i++) begin : g_btn
    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk(clk),
      .rst(rst),
      .btn(bus.btn[i]),
      .press(press[i])
    );
    assign clr[i] = bus.door_open && bus.cur_floor == floor_t'(i);
  end
  // clear outranks a press, so a call being served is never re-latched
  always_comb begin
    req_nx = req;
    for (int f = 0; f < NUM_FLOORS; f++)
      req_nx[f] = clr[f] ? 1'b0 : press[f] ? (CANCEL ? ~req[f] : 1'b1) : req[f];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req <= '0;
      any_req <= 1'b0;
    end else begin
      req <= req_nx;
      any_req <= |req_nx;
    end
  end
  assign bus.req = req;
  assign bus.any_req = any_req;
endmodule
